// File: rtl/co_acc_pkg.sv
// Shared definitions for the matrix-vector accumulator control path.
// Holds the job-controller FSM state type, the accumulate-index width and
// the limits that decide whether a requested accumulation length is legal.
package co_acc_pkg;

  // Width of cmd_k and cycle_num.
  localparam int unsigned CycleW = 9;

  // Smallest legal cmd_k, and the default upper limit (K_ACCUM_DEPTH).
  localparam int unsigned CmdKMin        = 1;
  localparam int unsigned CmdKMaxDefault = 64;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPrime = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StWrite = 3'd4
  } state_e;

  // True when k lies in [CmdKMin, max_k].
  function automatic logic cmd_k_legal(logic [CycleW-1:0] k, int unsigned max_k);
    return (32'(k) >= CmdKMin) && (32'(k) <= max_k);
  endfunction

endpackage

// File: rtl/mv_job_ctrl_if.sv
// Job-controller bundle: command handshake, abort, SRAM read addresses,
// PE core accumulate controls, outcome-SRAM write strobe and status pulses.
// master: the job issuer / datapath side. slave: the controller.
interface mv_job_ctrl_if #(
  parameter int unsigned AW_W = 6,
  parameter int unsigned AW_V = 6,
  parameter int unsigned AW_O = 5
);
  import co_acc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CycleW-1:0] cmd_k;
  logic [AW_O:0]     cmd_tiles;
  logic [AW_W-1:0]   cmd_w_base;
  logic [AW_V-1:0]   cmd_v_base;
  logic              abort;
  logic [AW_W-1:0]   sram_w_addr;
  logic [AW_V-1:0]   sram_v_addr;
  logic              alu_start;
  logic [CycleW-1:0] cycle_num;
  logic              outcome_we;
  logic [AW_O-1:0]   outcome_waddr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_k, cmd_tiles, cmd_w_base, cmd_v_base, abort,
    input  cmd_ready, sram_w_addr, sram_v_addr, alu_start, cycle_num,
    input  outcome_we, outcome_waddr, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_k, cmd_tiles, cmd_w_base, cmd_v_base, abort,
    output cmd_ready, sram_w_addr, sram_v_addr, alu_start, cycle_num,
    output outcome_we, outcome_waddr, busy, done, err
  );

endinterface

// File: rtl/mv_job_ctrl.sv
// Matrix-vector job controller. Accepts a job (k, tiles, weight/vector base),
// then for every tile: one PRIME cycle (SRAM read latency), k RUN cycles with
// alu_start high and cycle_num counting 1..k while both SRAM addresses step,
// PE_LATENCY DRAIN cycles, and one WRITE cycle that strobes the outcome row.
// Ports:
//   clk, srstn : clock, asynchronous active-low reset
//   bus        : mv_job_ctrl_if.slave (command, abort, SRAM/PE/outcome controls,
//                busy/done/err status)
// Every output except cmd_ready/busy is a register; cmd_ready/busy decode the
// state register only.
module mv_job_ctrl
  import co_acc_pkg::*;
#(
  parameter int unsigned K_ACCUM_DEPTH = CmdKMaxDefault,
  parameter int unsigned SRAM_W_DEPTH  = 64,
  parameter int unsigned SRAM_V_DEPTH  = 64,
  parameter int unsigned SRAM_O_DEPTH  = 32,
  parameter int unsigned PE_LATENCY    = 4
) (
  input logic          clk,
  input logic          srstn,
  mv_job_ctrl_if.slave bus
);

  localparam int unsigned AW_W   = $clog2(SRAM_W_DEPTH);
  localparam int unsigned AW_V   = $clog2(SRAM_V_DEPTH);
  localparam int unsigned AW_O   = $clog2(SRAM_O_DEPTH);
  localparam int unsigned TileW  = AW_O + 1;
  localparam int unsigned DrainW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CycleW-1:0] k_q, k_d;
  logic [TileW-1:0]  tiles_q, tiles_d;
  logic [AW_V-1:0]   v_base_q, v_base_d;
  logic [AW_O-1:0]   tile_q, tile_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [AW_W-1:0]   w_addr_q, w_addr_d;
  logic [AW_V-1:0]   v_addr_q, v_addr_d;
  logic              alu_start_q, alu_start_d;
  logic [CycleW-1:0] cycle_num_q, cycle_num_d;
  logic              outcome_we_q, outcome_we_d;
  logic [AW_O-1:0]   outcome_waddr_q, outcome_waddr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cmd_legal;
  logic              more_tiles;

  // Address steps wrap at the SRAM depth, which need not be a power of two.
  function automatic logic [AW_W-1:0] inc_w(logic [AW_W-1:0] a);
    return (a == AW_W'(SRAM_W_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [AW_V-1:0] inc_v(logic [AW_V-1:0] a);
    return (a == AW_V'(SRAM_V_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign cmd_legal = cmd_k_legal(bus.cmd_k, K_ACCUM_DEPTH) &&
                     (bus.cmd_tiles != '0) && (32'(bus.cmd_tiles) <= SRAM_O_DEPTH);

  assign more_tiles = (TileW'(tile_q) + TileW'(1)) < tiles_q;

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    tiles_d         = tiles_q;
    v_base_d        = v_base_q;
    tile_d          = tile_q;
    drain_d         = drain_q;
    w_addr_d        = w_addr_q;
    v_addr_d        = v_addr_q;
    outcome_waddr_d = outcome_waddr_q;
    alu_start_d     = 1'b0;
    cycle_num_d     = '0;
    outcome_we_d    = 1'b0;
    done_d          = 1'b0;
    err_d           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (cmd_legal) begin
            k_d      = bus.cmd_k;
            tiles_d  = bus.cmd_tiles;
            v_base_d = bus.cmd_v_base;
            tile_d   = '0;
            w_addr_d = bus.cmd_w_base;
            v_addr_d = bus.cmd_v_base;
            state_d  = StPrime;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPrime: begin
        // Base address was presented this cycle; its data lands in RUN cycle 1.
        alu_start_d = 1'b1;
        cycle_num_d = CycleW'(1);
        w_addr_d    = inc_w(w_addr_q);
        v_addr_d    = inc_v(v_addr_q);
        state_d     = StRun;
      end
      StRun: begin
        if (cycle_num_q == k_q) begin
          drain_d = '0;
          state_d = StDrain;
        end else begin
          alu_start_d = 1'b1;
          cycle_num_d = cycle_num_q + 1'b1;
          w_addr_d    = inc_w(w_addr_q);
          v_addr_d    = inc_v(v_addr_q);
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(PE_LATENCY - 1)) begin
          state_d = StWrite;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StWrite: begin
        outcome_we_d    = 1'b1;
        outcome_waddr_d = tile_q;
        if (more_tiles) begin
          tile_d   = tile_q + 1'b1;
          v_addr_d = v_base_q;  // weights keep streaming, vector restarts
          state_d  = StPrime;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including the write strobe of a WRITE cycle.
    if (bus.abort && (state_q != StIdle)) begin
      state_d         = StIdle;
      tile_d          = tile_q;
      drain_d         = drain_q;
      w_addr_d        = w_addr_q;
      v_addr_d        = v_addr_q;
      outcome_waddr_d = outcome_waddr_q;
      alu_start_d     = 1'b0;
      cycle_num_d     = '0;
      outcome_we_d    = 1'b0;
      done_d          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q         <= StIdle;
      k_q             <= '0;
      tiles_q         <= '0;
      v_base_q        <= '0;
      tile_q          <= '0;
      drain_q         <= '0;
      w_addr_q        <= '0;
      v_addr_q        <= '0;
      alu_start_q     <= 1'b0;
      cycle_num_q     <= '0;
      outcome_we_q    <= 1'b0;
      outcome_waddr_q <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      tiles_q         <= tiles_d;
      v_base_q        <= v_base_d;
      tile_q          <= tile_d;
      drain_q         <= drain_d;
      w_addr_q        <= w_addr_d;
      v_addr_q        <= v_addr_d;
      alu_start_q     <= alu_start_d;
      cycle_num_q     <= cycle_num_d;
      outcome_we_q    <= outcome_we_d;
      outcome_waddr_q <= outcome_waddr_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign bus.cmd_ready     = (state_q == StIdle);
  assign bus.busy          = (state_q != StIdle);
  assign bus.sram_w_addr   = w_addr_q;
  assign bus.sram_v_addr   = v_addr_q;
  assign bus.alu_start     = alu_start_q;
  assign bus.cycle_num     = cycle_num_q;
  assign bus.outcome_we    = outcome_we_q;
  assign bus.outcome_waddr = outcome_waddr_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_mv_job_ctrl.sv
// Bench for mv_job_ctrl: a job-timeline model (per-tile phase arithmetic)
// predicts every output each cycle; directed jobs plus literal expectations.
module tb_mv_job_ctrl;

  localparam int K_DEPTH  = 64;
  localparam int W_DEPTH  = 64;
  localparam int V_DEPTH  = 64;
  localparam int O_DEPTH  = 32;
  localparam int PE_LAT   = 4;
  localparam int AW_W     = $clog2(W_DEPTH);
  localparam int AW_V     = $clog2(V_DEPTH);
  localparam int AW_O     = $clog2(O_DEPTH);

  logic clk;
  logic srstn;

  mv_job_ctrl_if #(.AW_W(AW_W), .AW_V(AW_V), .AW_O(AW_O)) bus_if ();

  mv_job_ctrl #(
    .K_ACCUM_DEPTH(K_DEPTH),
    .SRAM_W_DEPTH (W_DEPTH),
    .SRAM_V_DEPTH (V_DEPTH),
    .SRAM_O_DEPTH (O_DEPTH),
    .PE_LATENCY   (PE_LAT)
  ) dut (
    .clk  (clk),
    .srstn(srstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state and predicted outputs.
  int m_active, m_d, m_k, m_tiles, m_wb, m_vb;
  int e_alu, e_cn, e_w, e_v, e_we, e_waddr, e_done, e_err;

  // Position d in the job (d=0 is tile 0's prime cycle) decides everything:
  // each tile spans L = 1 + k + PE_LAT + 1 cycles.
  task automatic model_phase();
    int len, j, p, kk;
    len = m_k + PE_LAT + 2;
    if (m_d == m_tiles * len) begin
      m_active = 0;
      e_we     = 1;
      e_waddr  = m_tiles - 1;
      e_done   = 1;
      e_alu    = 0;
      e_cn     = 0;
      e_w      = (m_wb + m_tiles * m_k) % W_DEPTH;
      e_v      = (m_vb + m_k) % V_DEPTH;
    end else begin
      j  = m_d / len;
      p  = m_d % len;
      kk = (p < m_k) ? p : m_k;
      if (p == 0 && j > 0) begin
        e_we    = 1;
        e_waddr = j - 1;
      end
      e_alu = (p >= 1 && p <= m_k) ? 1 : 0;
      e_cn  = (e_alu != 0) ? p : 0;
      e_w   = (m_wb + j * m_k + kk) % W_DEPTH;
      e_v   = (m_vb + kk) % V_DEPTH;
    end
  endtask

  initial begin
    m_active = 0; m_d = 0; m_k = 0; m_tiles = 0; m_wb = 0; m_vb = 0;
    e_alu = 0; e_cn = 0; e_w = 0; e_v = 0; e_we = 0; e_waddr = 0; e_done = 0; e_err = 0;
    forever begin
      @(posedge clk or negedge srstn);
      if (!srstn) begin
        m_active = 0; m_d = 0;
        e_alu = 0; e_cn = 0; e_w = 0; e_v = 0; e_we = 0; e_waddr = 0; e_done = 0; e_err = 0;
      end else begin
        e_we = 0; e_done = 0; e_err = 0;
        if (m_active == 0) begin
          if (bus_if.cmd_valid) begin
            if (bus_if.cmd_k == 0 || int'(bus_if.cmd_k) > K_DEPTH ||
                bus_if.cmd_tiles == 0 || int'(bus_if.cmd_tiles) > O_DEPTH) begin
              e_err = 1;
            end else begin
              m_active = 1;
              m_d      = 0;
              m_k      = int'(bus_if.cmd_k);
              m_tiles  = int'(bus_if.cmd_tiles);
              m_wb     = int'(bus_if.cmd_w_base);
              m_vb     = int'(bus_if.cmd_v_base);
              model_phase();
            end
          end
        end else if (bus_if.abort) begin
          m_active = 0;
          e_alu    = 0;
          e_cn     = 0;
        end else begin
          m_d++;
          model_phase();
        end
      end
    end
  end

  int checks, errors, cyc;
  int we_cnt, done_cnt, err_cnt, alu_cnt, busy_cnt, last_done_cyc;
  int we_mask;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: wait for the falling edge, compare every output, tally pulses.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("cmd_ready", int'(bus_if.cmd_ready), (m_active != 0) ? 0 : 1);
    chk("busy", int'(bus_if.busy), m_active);
    chk("alu_start", int'(bus_if.alu_start), e_alu);
    chk("cycle_num", int'(bus_if.cycle_num), e_cn);
    chk("sram_w_addr", int'(bus_if.sram_w_addr), e_w);
    chk("sram_v_addr", int'(bus_if.sram_v_addr), e_v);
    chk("outcome_we", int'(bus_if.outcome_we), e_we);
    chk("outcome_waddr", int'(bus_if.outcome_waddr), e_waddr);
    chk("done", int'(bus_if.done), e_done);
    chk("err", int'(bus_if.err), e_err);
    if (bus_if.outcome_we) begin
      we_cnt++;
      we_mask = we_mask | (1 << int'(bus_if.outcome_waddr));
    end
    if (bus_if.done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus_if.err) err_cnt++;
    if (bus_if.alu_start) alu_cnt++;
    if (bus_if.busy) busy_cnt++;
  endtask

  task automatic send(int k, int tiles, int wb, int vb);
    bus_if.cmd_k      = 9'(k);
    bus_if.cmd_tiles  = (AW_O + 1)'(tiles);
    bus_if.cmd_w_base = AW_W'(wb);
    bus_if.cmd_v_base = AW_V'(vb);
    bus_if.cmd_valid  = 1'b1;
    tick();
    bus_if.cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int n;
    n = 0;
    while (m_active != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("job_finished_in_time", m_active, 0);
  endtask

  task automatic clear_tally();
    we_cnt = 0; done_cnt = 0; err_cnt = 0; alu_cnt = 0; busy_cnt = 0; we_mask = 0;
  endtask

  initial begin
    int acc_cyc, n;
    checks = 0; errors = 0; cyc = 0; last_done_cyc = 0;
    clear_tally();
    srstn = 1'b0;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_k = '0; bus_if.cmd_tiles = '0;
    bus_if.cmd_w_base = '0; bus_if.cmd_v_base = '0; bus_if.abort = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", int'(bus_if.cmd_ready), 1);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_done", int'(bus_if.done), 0);
    srstn = 1'b1;
    tick();

    // k=4, tiles=1; cmd_valid held while busy must be ignored.
    clear_tally();
    send(4, 1, 0, 0);
    acc_cyc = cyc;
    bus_if.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus_if.cmd_valid = 1'b0;
    wait_idle(40);
    chk("j1_done_latency", last_done_cyc - acc_cyc, 10);
    chk("j1_alu_cycles", alu_cnt, 4);
    chk("j1_w_addr_end", int'(bus_if.sram_w_addr), 4);
    chk("j1_we_count", we_cnt, 1);
    chk("j1_we_rows", we_mask, 1);
    chk("j1_done_count", done_cnt, 1);
    tick();

    // k=64, tiles=3, bases 10/5.
    clear_tally();
    send(64, 3, 10, 5);
    wait_idle(300);
    chk("j2_w_addr_end", int'(bus_if.sram_w_addr), 10);
    chk("j2_v_addr_end", int'(bus_if.sram_v_addr), 5);
    chk("j2_we_rows", we_mask, 7);
    chk("j2_we_count", we_cnt, 3);
    chk("j2_done_count", done_cnt, 1);
    tick();

    // Illegal commands.
    clear_tally();
    send(0, 1, 0, 0);
    tick();
    send(65, 1, 0, 0);
    tick();
    send(4, 33, 0, 0);
    tick();
    chk("ill_err_count", err_cnt, 3);
    chk("ill_busy_cycles", busy_cnt, 0);
    chk("ill_we_count", we_cnt, 0);

    // Abort on the WRITE cycle of tile 1 of a 2-tile k=3 job (d = 9 + 8).
    clear_tally();
    send(3, 2, 20, 30);
    n = 0;
    while (!(m_active != 0 && m_d == 17) && n < 40) begin
      tick();
      n++;
    end
    chk("ab_reached_write", m_d, 17);
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    chk("ab_cmd_ready", int'(bus_if.cmd_ready), 1);
    tick();
    tick();
    chk("ab_no_row1", (we_mask >> 1) & 1, 0);
    chk("ab_we_count", we_cnt, 1);
    chk("ab_done_count", done_cnt, 0);

    // Abort in IDLE is ignored and a coincident command is accepted.
    clear_tally();
    bus_if.abort = 1'b1;
    send(2, 1, 1, 1);
    bus_if.abort = 1'b0;
    chk("idle_abort_accept_busy", int'(bus_if.busy), 1);
    wait_idle(40);
    chk("idle_abort_done", done_cnt, 1);
    tick();

    // Reset mid-RUN at cycle_num=20, then a fresh k=2 job.
    clear_tally();
    send(30, 1, 0, 0);
    n = 0;
    while (e_cn != 20 && n < 60) begin
      tick();
      n++;
    end
    chk("rst_reached_cn20", int'(bus_if.cycle_num), 20);
    srstn = 1'b0;
    #1;
    chk("mid_rst_alu", int'(bus_if.alu_start), 0);
    chk("mid_rst_cn", int'(bus_if.cycle_num), 0);
    chk("mid_rst_w_addr", int'(bus_if.sram_w_addr), 0);
    chk("mid_rst_busy", int'(bus_if.busy), 0);
    chk("mid_rst_cmd_ready", int'(bus_if.cmd_ready), 1);
    tick();
    srstn = 1'b1;
    tick();
    clear_tally();
    acc_cyc = 0;
    send(2, 1, 3, 7);
    acc_cyc = cyc;
    wait_idle(40);
    chk("post_rst_latency", last_done_cyc - acc_cyc, 8);
    chk("post_rst_w_end", int'(bus_if.sram_w_addr), 5);
    chk("post_rst_we_rows", we_mask, 1);
    chk("post_rst_done", done_cnt, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
